multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32I datapath.
- Replaces the single-cycle control drivers: per instruction it emits the datapath controls, plus PC and IR write enables, a data-memory request handshake and a writeback-source select.
- Supported subset: R-type and I-type ALU ops, LW, SW, BEQ, BNE, JAL. SYSTEM opcodes and illegal encodings halt the core.
- Sits between the instruction register and the data_path control inputs.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ready before bus error (≥1).
- CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  7  inst[6:0] from IR (stable DECODE onward)
- funct3  in  3  inst[14:12]
- funct7_5  in  1  inst[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completes current request
- ir_write  out  1  load IR from inst memory
- pc_write  out  1  commit next_pc into PC
- reg_write  out  1  register file write enable
- alu_src  out  1  1 = immediate operand
- alu_ctrl  out  4  ALU operation (package encoding)
- branch  out  1  instruction is a branch
- pc_sel_branch  out  1  branch taken
- jump  out  1  JAL redirect
- mem_req  out  1  data memory request
- mem_write  out  1  store qualifier of mem_req
- wb_sel  out  2  0 = ALU, 1 = MEM, 2 = PC+4
- halted  out  1  sticky halt
- illegal  out  1  sticky: halt caused by illegal instruction
- bus_err  out  1  sticky: halt caused by MEM timeout
- instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- Reset (async): state = FETCH; instret, halted, illegal, bus_err = 0. While reset_n is low, every output is 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Controls are combinational from state plus the instruction class latched in DECODE. Every control is 0 outside the state that uses it.
- FETCH: ir_write = 1 → DECODE.
- DECODE: register class and alu_ctrl from opcode/funct3/funct7_5.
  - Illegal → HALT, illegal = 1. Illegal means: unknown opcode; load with funct3 ≠ 010; store with funct3 ≠ 010; branch with funct3 not 000/001.
  - opcode 1110011 → HALT, illegal = 0.
  - Otherwise → EXEC.
- alu_ctrl decode:
  - ADD for I-type arithmetic, LW, SW; SUB for branches.
  - R-type and I-type by funct3:
    - 000: ADD, or SUB if R-type with funct7_5 = 1
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRL, or SRA if funct7_5 = 1 (R-type and I-type)
    - 110: OR
    - 111: AND
- alu_src = 1 for I-ALU/LW/SW, 0 for R/branch. Held valid EXEC through WB.
- EXEC:
  - ALU op → WB.
  - LW/SW → MEM.
  - Branch: branch = 1, pc_sel_branch = (BEQ & zero) | (BNE & ~zero), pc_write = 1, retire → FETCH.
  - JAL: jump = 1, reg_write = 1, wb_sel = 2, pc_write = 1, retire → FETCH.
- MEM:
  - mem_req = 1 (mem_write = 1 for SW), held until mem_ready.
  - 5-bit-or-wider wait counter cleared on MEM entry.
  - On mem_ready: SW → pc_write = 1, retire → FETCH; LW → WB.
  - If MEM_TIMEOUT cycles elapse without mem_ready → HALT, bus_err = 1, no pc_write.
  - mem_ready in the first MEM cycle is accepted (zero wait).
- WB: reg_write = 1, wb_sel = 1 for LW else 0, pc_write = 1, retire → FETCH.
- Retire: instret += 1, wrapping modulo 2^CNT_WIDTH. Exactly one pc_write per retired instruction.
- HALT: absorbing; halted = 1; all controls 0 until reset. mem_ready ignored.
- Latency (cycles per instruction):
  - branch/JAL: 3
  - ALU: 4
  - SW: 4 + wait
  - LW: 5 + wait
- Reset asserted mid-instruction: immediate return to FETCH. No partial reg_write or pc_write completes.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants
  - alu_ctrl enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9
  - wb_sel enum
  - state enum
- One sub-module, alu_decoder (combinational: class, funct3, funct7_5 → alu_ctrl, alu_src, illegal). The FSM and counters stay in the top.

Test Plan:
- ADD x3,x1,x2 (0x002081B3): states F,D,E,W. reg_write = 1 only in cycle 4, wb_sel = 0, alu_ctrl = SUB never, instret 0→1.
- BEQ with zero = 1 then zero = 0: pc_sel_branch 1 then 0. pc_write = 1 in EXEC both times, 3 cycles each, reg_write never.
- LW with mem_ready after 3 wait cycles: mem_req high exactly 4 cycles, mem_write = 0, then WB with wb_sel = 1; total 8 cycles.
- SW with mem_ready never (MEM_TIMEOUT = 16): mem_req high 16 cycles, then halted = bus_err = 1. No pc_write; instret unchanged; mem_ready afterwards has no effect.
- Opcode 0x7F, and LB (funct3 000): halted = illegal = 1 after DECODE; ECALL: halted = 1, illegal = 0.
- JAL, then reset_n pulsed low mid-LW in MEM: JAL asserts jump, reg_write, wb_sel = 2 together. Reset drops all outputs to 0 asynchronously and the FSM restarts in FETCH with instret = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller: opcodes, ALU operation
// encoding, writeback select, FSM states and the latched instruction class.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // ST_FETCH is all-zero so the debug state also reads 0 while in reset.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_SYSTEM = 3'd6,
        CLS_BAD    = 3'd7
    } instr_cls_e;

    function automatic instr_cls_e opcode_class(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_JAL:    return CLS_JAL;
            OP_SYSTEM: return CLS_SYSTEM;
            default:   return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of instruction class + funct fields into the ALU
// operation, operand select and a funct-level legality flag.
module alu_decoder
    import ctrl_pkg::*;
(
    input  instr_cls_e cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_ctrl_e  alu_ctrl,
    output logic       alu_src,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b0;
        illegal  = 1'b0;
        case (cls)
            CLS_R, CLS_I: begin
                alu_src = (cls == CLS_I);
                // funct7_5 selects SUB only for R-type; ADDI ignores it.
                case (funct3)
                    3'b000: alu_ctrl = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                endcase
            end
            CLS_LOAD, CLS_STORE: begin
                alu_src = 1'b1;
                illegal = (funct3 != 3'b010);
            end
            CLS_BRANCH: begin
                alu_ctrl = ALU_SUB;
                illegal  = (funct3[2:1] != 2'b00);
            end
            CLS_JAL, CLS_SYSTEM: begin
                alu_ctrl = ALU_ADD;
            end
            CLS_BAD: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing the RV32I datapath through
// FETCH/DECODE/EXEC/MEM/WB, with sticky halt reporting and a retire counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 alu_src,
    output logic [3:0]           alu_ctrl,
    output logic                 branch,
    output logic                 pc_sel_branch,
    output logic                 jump,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic [1:0]           wb_sel,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [CNT_WIDTH-1:0] instret,
    output state_e               dbg_state
);

    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 5) ? $clog2(MEM_TIMEOUT + 1) : 5;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Handshake: mem_req stays high every MEM cycle; the cycle in which
    // mem_ready is sampled high (including the first) completes the access.

    state_e                state_q,    state_d;
    instr_cls_e            cls_q,      cls_d;
    alu_ctrl_e             alu_ctrl_q, alu_ctrl_d;
    logic                  alu_src_q,  alu_src_d;
    logic                  bne_q,      bne_d;
    logic [WAIT_W-1:0]     wait_q,     wait_d;
    logic [CNT_WIDTH-1:0]  instret_q,  instret_d;
    logic                  illegal_q,  illegal_d;
    logic                  bus_err_q,  bus_err_d;

    instr_cls_e cls_dec;
    alu_ctrl_e  dec_alu_ctrl;
    logic       dec_alu_src;
    logic       dec_illegal;

    assign cls_dec = opcode_class(opcode);

    alu_decoder u_alu_decoder (
        .cls      (cls_dec),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (dec_alu_ctrl),
        .alu_src  (dec_alu_src),
        .illegal  (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_ctrl_d = alu_ctrl_q;
        alu_src_d  = alu_src_q;
        bne_d      = bne_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        instret_d  = pc_write ? instret_q + 1'b1 : instret_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d      = cls_dec;
                alu_ctrl_d = dec_alu_ctrl;
                alu_src_d  = dec_alu_src;
                bne_d      = funct3[0];
                if (dec_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (cls_dec == CLS_SYSTEM) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_BRANCH, CLS_JAL: state_d = ST_FETCH;
                    CLS_LOAD, CLS_STORE: begin
                        state_d = ST_MEM;
                        wait_d  = '0;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            cls_q      <= CLS_R;
            alu_ctrl_q <= ALU_ADD;
            alu_src_q  <= 1'b0;
            bne_q      <= 1'b0;
            wait_q     <= '0;
            instret_q  <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_src_q  <= alu_src_d;
            bne_q      <= bne_d;
            wait_q     <= wait_d;
            instret_q  <= instret_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Controls are decoded from state and latched class; reset_n gates them
    // so nothing (notably ir_write in FETCH) is visible while reset is held.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src       = 1'b0;
        alu_ctrl      = 4'd0;
        branch        = 1'b0;
        pc_sel_branch = 1'b0;
        jump          = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        wb_sel        = WB_ALU;
        if (reset_n) begin
            case (state_q)
                ST_FETCH: ir_write = 1'b1;
                ST_EXEC: begin
                    alu_src  = alu_src_q;
                    alu_ctrl = alu_ctrl_q;
                    if (cls_q == CLS_BRANCH) begin
                        branch        = 1'b1;
                        pc_sel_branch = bne_q ? ~zero : zero;
                        pc_write      = 1'b1;
                    end else if (cls_q == CLS_JAL) begin
                        jump      = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_write  = 1'b1;
                    end
                end
                ST_MEM: begin
                    alu_src   = alu_src_q;
                    alu_ctrl  = alu_ctrl_q;
                    mem_req   = 1'b1;
                    mem_write = (cls_q == CLS_STORE);
                    pc_write  = mem_ready && (cls_q == CLS_STORE);
                end
                ST_WB: begin
                    alu_src   = alu_src_q;
                    alu_ctrl  = alu_ctrl_q;
                    reg_write = 1'b1;
                    wb_sel    = (cls_q == CLS_LOAD) ? WB_MEM : WB_ALU;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halted    = reset_n & (state_q == ST_HALT);
    assign illegal   = reset_n & illegal_q;
    assign bus_err   = reset_n & bus_err_q;
    assign instret   = instret_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction trace model built from the
// ISA rules, a directed vector table, random instructions and a reset case.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, reg_write, alu_src, branch, pc_sel_branch;
  logic        jump, mem_req, mem_write, halted, illegal, bus_err;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wb_sel;
  logic [31:0] instret;
  ctrl_pkg::state_e dbg_state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .branch(branch),
    .pc_sel_branch(pc_sel_branch), .jump(jump), .mem_req(mem_req),
    .mem_write(mem_write), .wb_sel(wb_sel), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .instret(instret),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        ir_write, pc_write, reg_write, alu_src;
    logic [3:0]  alu_ctrl;
    logic        branch, pc_sel_branch, jump, mem_req, mem_write;
    logic [1:0]  wb_sel;
    logic        halted, illegal, bus_err;
    logic [31:0] instret;
  } ctl_t;
  localparam int CTL_W = $bits(ctl_t);

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zr;
    int         wait_n;
    int         exp_cycles;
    logic [3:0] exp_alu;
  } vec_t;

  logic [CTL_W-1:0] exp_q[$];
  logic             rdy_q[$];
  vec_t             vecs[$];

  int tests_run = 0;
  int tests_failed = 0;
  int m_instret = 0;
  bit m_halted = 0, m_illegal = 0, m_bus_err = 0;

  // ---------------- reference model ----------------
  // kinds: 0 R-ALU, 1 I-ALU, 2 LW, 3 SW, 4 branch, 5 JAL, 6 system, 7 illegal
  function automatic int ref_kind(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'h33:   return 0;
      7'h13:   return 1;
      7'h03:   return (f3 == 3'd2) ? 2 : 7;
      7'h23:   return (f3 == 3'd2) ? 3 : 7;
      7'h63:   return (f3 <= 3'd1) ? 4 : 7;
      7'h6F:   return 5;
      7'h73:   return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input int kind, input logic [2:0] f3, input logic f7);
    logic [3:0] by_f3 [8];
    by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (kind == 4) return 4'd1;
    if (kind > 1) return 4'd0;
    if (f3 == 3'd0 && kind == 0 && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd7;
    return by_f3[f3];
  endfunction

  task automatic push(input ctl_t c, input logic rdy);
    c.instret = 32'(m_instret);
    exp_q.push_back(c);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_halt(input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.halted = 1'b1;
      c.illegal = m_illegal;
      c.bus_err = m_bus_err;
      push(c, 1'b1);
    end
  endtask

  // wait_n = number of not-ready MEM cycles before mem_ready; >= TIMEOUT means never.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic zr, input int wait_n);
    ctl_t c;
    int kind;
    kind = ref_kind(op, f3);
    opcode = op; funct3 = f3; funct7_5 = f7; zero = zr;
    c = '0; c.ir_write = 1'b1; push(c, 1'($urandom_range(0, 1)));
    c = '0; push(c, 1'($urandom_range(0, 1)));
    if (kind >= 6) begin
      m_halted = 1; m_illegal = (kind == 7);
      push_halt(3);
      return;
    end
    c = '0;
    c.alu_src = (kind == 1 || kind == 2 || kind == 3);
    c.alu_ctrl = ref_alu(kind, f3, f7);
    case (kind)
      4: begin
        c.branch = 1'b1; c.pc_write = 1'b1;
        c.pc_sel_branch = f3[0] ? !zr : zr;
        push(c, 1'($urandom_range(0, 1))); m_instret++;
      end
      5: begin
        c.jump = 1'b1; c.reg_write = 1'b1; c.wb_sel = 2'd2; c.pc_write = 1'b1;
        push(c, 1'($urandom_range(0, 1))); m_instret++;
      end
      0, 1: begin
        push(c, 1'($urandom_range(0, 1)));
        c.reg_write = 1'b1; c.pc_write = 1'b1;
        push(c, 1'($urandom_range(0, 1))); m_instret++;
      end
      default: begin
        push(c, 1'($urandom_range(0, 1)));
        c.mem_req = 1'b1; c.mem_write = (kind == 3);
        if (wait_n >= TIMEOUT) begin
          for (int j = 0; j < TIMEOUT; j++) push(c, 1'b0);
          m_halted = 1; m_bus_err = 1;
          push_halt(3);
        end else begin
          for (int j = 0; j < wait_n; j++) push(c, 1'b0);
          c.pc_write = (kind == 3);
          push(c, 1'b1);
          if (kind == 3) m_instret++;
          else begin
            c.mem_req = 1'b0; c.mem_write = 1'b0;
            c.reg_write = 1'b1; c.pc_write = 1'b1; c.wb_sel = 2'd1;
            push(c, 1'($urandom_range(0, 1))); m_instret++;
          end
        end
      end
    endcase
  endtask

  // ---------------- checking ----------------
  function automatic ctl_t sample();
    ctl_t c;
    c.ir_write = ir_write; c.pc_write = pc_write; c.reg_write = reg_write;
    c.alu_src = alu_src; c.alu_ctrl = alu_ctrl; c.branch = branch;
    c.pc_sel_branch = pc_sel_branch; c.jump = jump; c.mem_req = mem_req;
    c.mem_write = mem_write; c.wb_sel = wb_sel; c.halted = halted;
    c.illegal = illegal; c.bus_err = bus_err; c.instret = instret;
    return c;
  endfunction

  task automatic check_vec(input string name, input int k, input logic [CTL_W-1:0] got,
                           input logic [CTL_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Starts and ends at posedge+1; applies queued mem_ready, samples at negedge.
  task automatic run_trace(input string name, input int max_cycles,
                           output int obs_cycles, output logic [3:0] obs_alu);
    ctl_t got;
    logic [CTL_W-1:0] exp;
    int k;
    k = 0; obs_cycles = 0; obs_alu = '0;
    while (exp_q.size() > 0 && k < max_cycles) begin
      exp = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      got = sample();
      check_vec(name, k, got, exp);
      if (k == 2) obs_alu = got.alu_ctrl;
      if (obs_cycles == 0 && (got.pc_write || got.halted)) obs_cycles = got.halted ? k : k + 1;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic reset_model();
    m_instret = 0; m_halted = 0; m_illegal = 0; m_bus_err = 0;
    exp_q.delete(); rdy_q.delete();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    #3;
    check_vec("reset_outputs", 0, sample(), '0);
    check_int("reset_state", int'(dbg_state), int'(ctrl_pkg::ST_FETCH));
    @(posedge clk); #1;
    reset_n = 1'b1;
    reset_model();
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic zr, input int wait_n, input int cyc, input logic [3:0] alu);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.zr = zr; v.wait_n = wait_n;
    v.exp_cycles = cyc; v.exp_alu = alu;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    logic [3:0] oa;
    int kind_sel, wait_n;
    logic [6:0] op;

    // op, f3, f7, zero, wait, cycles-to-retire (or to halt), alu_ctrl in EXEC
    add_vec(7'h33, 3'd0, 1'b0, 1'b0, 0, 4, 4'd0);   // ADD x3,x1,x2
    add_vec(7'h33, 3'd0, 1'b1, 1'b0, 0, 4, 4'd1);   // SUB
    add_vec(7'h33, 3'd5, 1'b1, 1'b0, 0, 4, 4'd7);   // SRA
    add_vec(7'h13, 3'd5, 1'b1, 1'b0, 0, 4, 4'd7);   // SRAI
    add_vec(7'h13, 3'd0, 1'b1, 1'b0, 0, 4, 4'd0);   // ADDI ignores funct7_5
    add_vec(7'h33, 3'd3, 1'b0, 1'b0, 0, 4, 4'd9);   // SLTU
    add_vec(7'h13, 3'd2, 1'b0, 1'b0, 0, 4, 4'd8);   // SLTI
    add_vec(7'h13, 3'd7, 1'b0, 1'b0, 0, 4, 4'd2);   // ANDI
    add_vec(7'h13, 3'd6, 1'b0, 1'b0, 0, 4, 4'd3);   // ORI
    add_vec(7'h33, 3'd4, 1'b0, 1'b0, 0, 4, 4'd4);   // XOR
    add_vec(7'h33, 3'd1, 1'b0, 1'b0, 0, 4, 4'd5);   // SLL
    add_vec(7'h33, 3'd5, 1'b0, 1'b0, 0, 4, 4'd6);   // SRL
    add_vec(7'h63, 3'd0, 1'b0, 1'b1, 0, 3, 4'd1);   // BEQ taken
    add_vec(7'h63, 3'd0, 1'b0, 1'b0, 0, 3, 4'd1);   // BEQ not taken
    add_vec(7'h63, 3'd1, 1'b0, 1'b0, 0, 3, 4'd1);   // BNE taken
    add_vec(7'h63, 3'd1, 1'b0, 1'b1, 0, 3, 4'd1);   // BNE not taken
    add_vec(7'h6F, 3'd0, 1'b0, 1'b0, 0, 3, 4'd0);   // JAL
    add_vec(7'h03, 3'd2, 1'b0, 1'b0, 3, 8, 4'd0);   // LW, 3 wait cycles
    add_vec(7'h03, 3'd2, 1'b0, 1'b0, 0, 5, 4'd0);   // LW zero wait
    add_vec(7'h23, 3'd2, 1'b0, 1'b0, 0, 4, 4'd0);   // SW zero wait
    add_vec(7'h23, 3'd2, 1'b0, 1'b0, 15, 19, 4'd0); // SW ready on last allowed cycle
    add_vec(7'h03, 3'd2, 1'b0, 1'b0, 15, 20, 4'd0); // LW ready on last allowed cycle
    add_vec(7'h23, 3'd2, 1'b0, 1'b0, 99, 19, 4'd0); // SW never ready -> bus error
    add_vec(7'h7F, 3'd0, 1'b0, 1'b0, 0, 2, 4'd0);   // unknown opcode
    add_vec(7'h03, 3'd0, 1'b0, 1'b0, 0, 2, 4'd0);   // LB unsupported
    add_vec(7'h23, 3'd1, 1'b0, 1'b0, 0, 2, 4'd0);   // SH unsupported
    add_vec(7'h63, 3'd4, 1'b0, 1'b0, 0, 2, 4'd0);   // BLT unsupported
    add_vec(7'h73, 3'd0, 1'b0, 1'b0, 0, 2, 4'd0);   // ECALL

    @(posedge clk); #1;
    apply_reset();

    foreach (vecs[i]) begin
      model_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zr, vecs[i].wait_n);
      run_trace($sformatf("vec%0d", i), 1000, oc, oa);
      check_int($sformatf("vec%0d_cycles", i), oc, vecs[i].exp_cycles);
      check_int($sformatf("vec%0d_alu", i), int'(oa), int'(vecs[i].exp_alu));
      check_int($sformatf("vec%0d_instret", i), int'(instret), m_instret);
      if (m_halted) apply_reset();
    end

    for (int n = 0; n < 80; n++) begin
      kind_sel = $urandom_range(0, 9);
      case (kind_sel)
        0, 1:    op = 7'h33;
        2, 3:    op = 7'h13;
        4:       op = 7'h03;
        5:       op = 7'h23;
        6:       op = 7'h63;
        7:       op = 7'h6F;
        8:       op = 7'h73;
        default: op = 7'($urandom);
      endcase
      wait_n = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
      model_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), wait_n);
      run_trace($sformatf("rand%0d", n), 1000, oc, oa);
      check_int($sformatf("rand%0d_instret", n), int'(instret), m_instret);
      if (m_halted) apply_reset();
    end

    // JAL, then reset asserted while an LW is waiting in MEM.
    model_instr(7'h6F, 3'd0, 1'b0, 1'b0, 0);
    run_trace("jal_pre_reset", 1000, oc, oa);
    model_instr(7'h03, 3'd2, 1'b0, 1'b0, 10);
    run_trace("lw_pre_reset", 5, oc, oa);
    mem_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset", 0, sample(), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    reset_model();
    model_instr(7'h33, 3'd0, 1'b0, 1'b0, 0);
    run_trace("add_after_reset", 1000, oc, oa);
    check_int("add_after_reset_cycles", oc, 4);
    check_int("add_after_reset_instret", int'(instret), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
